// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller: registered level, status flags, sticky overflow/underflow.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read behaviour; default is standard read.
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  CLK,
    input  logic                  RST_ASYNC,
    input  logic                  WR_EN_IN,
    input  logic [DATA_WIDTH-1:0] WR_DATA_IN,
    input  logic                  RD_EN_IN,
    input  logic                  ERR_CLR_IN,
    output logic [DATA_WIDTH-1:0] RD_DATA_OUT,
    output logic                  RD_VALID_OUT,
    output logic                  FULL_OUT,
    output logic                  EMPTY_OUT,
    output logic                  AFULL_OUT,
    output logic                  AEMPTY_OUT,
    output logic [ADDR_WIDTH:0]   LEVEL_OUT,
    output logic                  OVERFLOW_OUT,
    output logic                  UNDERFLOW_OUT
);

    localparam int                DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LVL_FULL   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LVL_AFULL  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] LVL_AEMPTY = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0] ONE        = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_level;
    logic                  r_ovf;
    logic                  r_udf;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [DATA_WIDTH-1:0] w_head;

    // Flags come from the registered level so they are glitch-free and reset with it.
    assign EMPTY_OUT     = (r_level == '0);
    assign FULL_OUT      = (r_level == LVL_FULL);
    assign AFULL_OUT     = (r_level >= LVL_AFULL);
    assign AEMPTY_OUT    = (r_level <= LVL_AEMPTY);
    assign LEVEL_OUT     = r_level;
    assign OVERFLOW_OUT  = r_ovf;
    assign UNDERFLOW_OUT = r_udf;

    assign w_wr_acc = WR_EN_IN & ~FULL_OUT;
    assign w_rd_acc = RD_EN_IN & ~EMPTY_OUT;
    assign w_head   = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];

    always_ff @(posedge CLK) begin
        if (w_wr_acc)
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= WR_DATA_IN;
    end

    always_ff @(posedge CLK or posedge RST_ASYNC) begin
        if (RST_ASYNC) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_wr_acc)
                r_wr_ptr <= r_wr_ptr + ONE;
            if (w_rd_acc)
                r_rd_ptr <= r_rd_ptr + ONE;
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_level <= r_level + ONE;
                2'b01:   r_level <= r_level - ONE;
                default: r_level <= r_level;
            endcase
            // Set has priority over a same-cycle clear.
            if (WR_EN_IN && FULL_OUT)
                r_ovf <= 1'b1;
            else if (ERR_CLR_IN)
                r_ovf <= 1'b0;
            if (RD_EN_IN && EMPTY_OUT)
                r_udf <= 1'b1;
            else if (ERR_CLR_IN)
                r_udf <= 1'b0;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head is presented directly; zero while empty keeps the reset-state output defined.
    assign RD_DATA_OUT  = EMPTY_OUT ? '0 : w_head;
    assign RD_VALID_OUT = ~EMPTY_OUT;
`else
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    always_ff @(posedge CLK or posedge RST_ASYNC) begin
        if (RST_ASYNC) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc)
                r_rd_data <= w_head;
        end
    end

    assign RD_DATA_OUT  = r_rd_data;
    assign RD_VALID_OUT = r_rd_valid;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Randomized + directed bench for sync_fifo_ctrl against a queue-based reference model.
module tb_sync_fifo_ctrl;

    logic       CLK = 1'b0;
    logic       RST_ASYNC;
    logic       WR_EN_IN;
    logic [7:0] WR_DATA_IN;
    logic       RD_EN_IN;
    logic       ERR_CLR_IN;
    logic [7:0] RD_DATA_OUT;
    logic       RD_VALID_OUT;
    logic       FULL_OUT, EMPTY_OUT, AFULL_OUT, AEMPTY_OUT;
    logic [4:0] LEVEL_OUT;
    logic       OVERFLOW_OUT, UNDERFLOW_OUT;

    sync_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_THRESH(12), .AEMPTY_THRESH(4)) dut (
        .CLK(CLK), .RST_ASYNC(RST_ASYNC),
        .WR_EN_IN(WR_EN_IN), .WR_DATA_IN(WR_DATA_IN),
        .RD_EN_IN(RD_EN_IN), .ERR_CLR_IN(ERR_CLR_IN),
        .RD_DATA_OUT(RD_DATA_OUT), .RD_VALID_OUT(RD_VALID_OUT),
        .FULL_OUT(FULL_OUT), .EMPTY_OUT(EMPTY_OUT),
        .AFULL_OUT(AFULL_OUT), .AEMPTY_OUT(AEMPTY_OUT),
        .LEVEL_OUT(LEVEL_OUT),
        .OVERFLOW_OUT(OVERFLOW_OUT), .UNDERFLOW_OUT(UNDERFLOW_OUT)
    );

    always #5 CLK = ~CLK;

    // Reference model: contents as a queue, flags recomputed from its size.
    logic [7:0] q[$];
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ovf, m_udf;
    int         n_chk  = 0;
    int         n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("level",  32'(LEVEL_OUT),     32'(n));
        chk("empty",  32'(EMPTY_OUT),     32'(n == 0));
        chk("full",   32'(FULL_OUT),      32'(n == 16));
        chk("afull",  32'(AFULL_OUT),     32'(n >= 12));
        chk("aempty", 32'(AEMPTY_OUT),    32'(n <= 4));
        chk("ovf",    32'(OVERFLOW_OUT),  32'(m_ovf));
        chk("udf",    32'(UNDERFLOW_OUT), 32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
        chk("valid",  32'(RD_VALID_OUT),  32'(n != 0));
        chk("rdata",  32'(RD_DATA_OUT),   (n != 0) ? 32'(q[0]) : 32'h0);
`else
        chk("valid",  32'(RD_VALID_OUT),  32'(m_valid));
        chk("rdata",  32'(RD_DATA_OUT),   32'(m_data));
`endif
    endtask

    // Called at a falling edge: drive, advance the model one clock, then check at the next falling edge.
    task automatic step(input logic wr, input logic [7:0] din, input logic rd, input logic clr);
        logic full, empty;
        WR_EN_IN   = wr;
        WR_DATA_IN = din;
        RD_EN_IN   = rd;
        ERR_CLR_IN = clr;
        full  = (q.size() == 16);
        empty = (q.size() == 0);
        if (wr && full)      m_ovf = 1'b1;
        else if (clr)        m_ovf = 1'b0;
        if (rd && empty)     m_udf = 1'b1;
        else if (clr)        m_udf = 1'b0;
        m_valid = rd && !empty;
        if (rd && !empty) m_data = q.pop_front();
        if (wr && !full)  q.push_back(din);
        @(posedge CLK);
        @(negedge CLK);
        check_all();
    endtask

    initial begin
        RST_ASYNC  = 1'b1;
        WR_EN_IN   = 1'b0;
        WR_DATA_IN = 8'h00;
        RD_EN_IN   = 1'b0;
        ERR_CLR_IN = 1'b0;
        model_reset();
        #2;
        check_all();
        @(negedge CLK);
        @(negedge CLK);
        RST_ASYNC = 1'b0;
        @(negedge CLK);
        check_all();

        // Fill to 15, then to full.
        for (int i = 0; i < 15; i++) step(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
        chk("lvl15",   32'(LEVEL_OUT), 32'd15);
        chk("afull15", 32'(AFULL_OUT), 32'd1);
        chk("full15",  32'(FULL_OUT),  32'd0);
        step(1'b1, 8'h20, 1'b0, 1'b0);
        chk("full16",  32'(FULL_OUT),  32'd1);
        chk("lvl16",   32'(LEVEL_OUT), 32'd16);

        // Overflow and clear.
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_set", 32'(OVERFLOW_OUT), 32'd1);
        chk("ovf_lvl", 32'(LEVEL_OUT),    32'd16);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", 32'(OVERFLOW_OUT), 32'd0);
        // Write while full with a same-cycle read: write rejected, level drops.
        step(1'b1, 8'hBB, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Drain, then underflow.
        while (q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("drain_empty", 32'(EMPTY_OUT), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("udf_set", 32'(UNDERFLOW_OUT), 32'd1);
        // Set wins over a same-cycle clear.
        step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("udf_prio", 32'(UNDERFLOW_OUT), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Directed FIFO order from a fresh fill.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
            chk("drain_data", 32'(RD_DATA_OUT), 32'(8'h11 + i));
`endif
        end

        // Level 8 with 40 cycles of simultaneous read/write; pointers wrap.
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'(8'h48 + i), 1'b1, 1'b0);
            chk("steady_lvl", 32'(LEVEL_OUT), 32'd8);
        end
        while (q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0);

`ifdef SYNC_FIFO_FWFT_EN
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("fwft_valid", 32'(RD_VALID_OUT), 32'd1);
        chk("fwft_data",  32'(RD_DATA_OUT),  32'h5A);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fwft_pop",   32'(RD_VALID_OUT), 32'd0);
`endif

        // Random traffic: fill-biased, then drain-biased, then balanced.
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 150; i++) begin
                int wp;
                wp = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
                step(1'(($urandom % 100) < wp), 8'($urandom),
                     1'(($urandom % 100) < (100 - wp)), 1'(($urandom % 16) == 0));
            end
        end

        // Reset between edges during a burst at level 6.
        while (q.size() > 6) step(1'b0, 8'h00, 1'b1, 1'b0);
        while (q.size() < 6) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'hC3, 1'b1, 1'b0);
        chk("pre_rst_lvl", 32'(LEVEL_OUT), 32'd5);
        WR_EN_IN = 1'b1;
        RD_EN_IN = 1'b1;
        #2 RST_ASYNC = 1'b1;
        #1;
        chk("rst_level",  32'(LEVEL_OUT),     32'd0);
        chk("rst_empty",  32'(EMPTY_OUT),     32'd1);
        chk("rst_aempty", 32'(AEMPTY_OUT),    32'd1);
        chk("rst_full",   32'(FULL_OUT),      32'd0);
        chk("rst_afull",  32'(AFULL_OUT),     32'd0);
        chk("rst_rdata",  32'(RD_DATA_OUT),   32'd0);
        chk("rst_valid",  32'(RD_VALID_OUT),  32'd0);
        chk("rst_ovf",    32'(OVERFLOW_OUT),  32'd0);
        chk("rst_udf",    32'(UNDERFLOW_OUT), 32'd0);
        WR_EN_IN = 1'b0;
        RD_EN_IN = 1'b0;
        @(negedge CLK);
        RST_ASYNC = 1'b0;
        model_reset();
        @(negedge CLK);
        check_all();
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0);
        while (q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
